// File: rtl/itcm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : itcm_arbiter
// Description : Fetch/loader arbiter and sequencer for the dual 16-bit ITCM
//               banks. Optional boot hold: ITCM_BOOT_HOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module itcm_arbiter #(
    parameter int DEPTH    = 1024,
    parameter int WAIT_MAX = 4,
    localparam int AW      = $clog2(DEPTH),
    localparam int ADDR_W  = AW + 2
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    // loader / debug port
    input  logic              l_req,
    input  logic              l_we,
    input  logic [AW-1:0]     l_addr,
    input  logic [31:0]       l_wdata,
    input  logic [3:0]        l_wstrb,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    // bank 0 (bytes 2..3 of each word)
    output logic              b0_en,
    output logic              b0_we,
    output logic [AW-1:0]     b0_addr,
    output logic [15:0]       b0_wdata,
    output logic [1:0]        b0_wmask,
    input  logic [15:0]       b0_rdata,
    // bank 1 (bytes 0..1 of each word)
    output logic              b1_en,
    output logic              b1_we,
    output logic [AW-1:0]     b1_addr,
    output logic [15:0]       b1_wdata,
    output logic [1:0]        b1_wmask,
    input  logic [15:0]       b1_rdata,
    input  logic              boot_done
);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] c_own_none  = 2'd0;
    localparam logic [1:0] c_own_fetch = 2'd1;
    localparam logic [1:0] c_own_lrd   = 2'd2;
    localparam logic [3:0] c_wait_max  = 4'(WAIT_MAX);

`ifdef ITCM_BOOT_HOLD_EN
    localparam state_t c_state_rst = ST_BOOT;
`else
    localparam state_t c_state_rst = ST_RUN;
`endif

    state_t        r_state;
    logic [3:0]    r_wait_cnt;
    logic [1:0]    r_resp_owner;
    logic          r_resp_mis;

    logic          w_run;
    logic          w_force;
    logic          w_f_gnt;
    logic          w_l_gnt;
    logic [AW-1:0] w_f_idx;
    logic          w_f_mis;
    logic          w_unused;

    assign w_run   = (r_state == ST_RUN);
    assign w_f_idx = f_addr[ADDR_W-1:2];
    assign w_f_mis = f_addr[1];

    // A starved loader overrides fetch priority once its wait count saturates.
    assign w_force = l_req && (r_wait_cnt == c_wait_max);

    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (!reset) begin
            w_f_gnt = w_run && f_req && !w_force;
            w_l_gnt = l_req && !w_f_gnt;
        end
    end

    assign f_gnt = w_f_gnt;
    assign l_gnt = w_l_gnt;

    always_comb begin
        b0_en    = 1'b0;
        b0_we    = 1'b0;
        b0_addr  = '0;
        b0_wdata = '0;
        b0_wmask = '0;
        b1_en    = 1'b0;
        b1_we    = 1'b0;
        b1_addr  = '0;
        b1_wdata = '0;
        b1_wmask = '0;
        if (w_f_gnt) begin
            b0_en   = 1'b1;
            b1_en   = 1'b1;
            b0_addr = w_f_idx;
            // Misaligned: upper halfword lives in the next word of bank1; wraps at DEPTH.
            b1_addr = w_f_mis ? (w_f_idx + AW'(1)) : w_f_idx;
        end else if (w_l_gnt) begin
            b0_addr = l_addr;
            b1_addr = l_addr;
            if (l_we) begin
                b0_en    = |l_wstrb[3:2];
                b1_en    = |l_wstrb[1:0];
                b0_we    = |l_wstrb[3:2];
                b1_we    = |l_wstrb[1:0];
                b0_wdata = l_wdata[31:16];
                b1_wdata = l_wdata[15:0];
                b0_wmask = l_wstrb[3:2];
                b1_wmask = l_wstrb[1:0];
            end else begin
                b0_en = 1'b1;
                b1_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_state_rst;
            r_wait_cnt   <= 4'd0;
            r_resp_owner <= c_own_none;
            r_resp_mis   <= 1'b0;
        end else begin
`ifdef ITCM_BOOT_HOLD_EN
            if ((r_state == ST_BOOT) && boot_done) begin
                r_state <= ST_RUN;
            end
`else
            r_state <= ST_RUN;
`endif
            if (!l_req || w_l_gnt) begin
                r_wait_cnt <= 4'd0;
            end else if (r_wait_cnt < c_wait_max) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end

            if (w_f_gnt) begin
                r_resp_owner <= c_own_fetch;
                r_resp_mis   <= w_f_mis;
            end else if (w_l_gnt && !l_we) begin
                r_resp_owner <= c_own_lrd;
                r_resp_mis   <= 1'b0;
            end else begin
                r_resp_owner <= c_own_none;
                r_resp_mis   <= 1'b0;
            end
        end
    end

    assign f_rvalid = (r_resp_owner == c_own_fetch);
    assign l_rvalid = (r_resp_owner == c_own_lrd);

    always_comb begin
        f_rdata = 32'd0;
        l_rdata = 32'd0;
        if (f_rvalid) begin
            f_rdata = r_resp_mis ? {b1_rdata, b0_rdata} : {b0_rdata, b1_rdata};
        end
        if (l_rvalid) begin
            l_rdata = {b0_rdata, b1_rdata};
        end
    end

    assign w_unused = ^{f_addr[0], boot_done};

endmodule
`default_nettype wire

// File: tb/tb_itcm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_itcm_arbiter
// Description : Directed self-checking bench for itcm_arbiter with bank models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itcm_arbiter;

    localparam int DEPTH  = 1024;
    localparam int AW     = 10;
    localparam int ADDR_W = 12;

    logic              clk;
    logic              reset;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              l_req;
    logic              l_we;
    logic [AW-1:0]     l_addr;
    logic [31:0]       l_wdata;
    logic [3:0]        l_wstrb;
    logic              l_gnt;
    logic              l_rvalid;
    logic [31:0]       l_rdata;
    logic              b0_en, b1_en, b0_we, b1_we;
    logic [AW-1:0]     b0_addr, b1_addr;
    logic [15:0]       b0_wdata, b1_wdata;
    logic [1:0]        b0_wmask, b1_wmask;
    logic [15:0]       b0_rd, b1_rd;
    logic              boot_done;

    logic [15:0] m0 [DEPTH];
    logic [15:0] m1 [DEPTH];

    int n_chk;
    int n_fail;

    itcm_arbiter #(.DEPTH(DEPTH), .WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_wstrb(l_wstrb), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .b0_en(b0_en), .b0_we(b0_we), .b0_addr(b0_addr), .b0_wdata(b0_wdata),
        .b0_wmask(b0_wmask), .b0_rdata(b0_rd),
        .b1_en(b1_en), .b1_we(b1_we), .b1_addr(b1_addr), .b1_wdata(b1_wdata),
        .b1_wmask(b1_wmask), .b1_rdata(b1_rd),
        .boot_done(boot_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-masked synchronous banks, read data one cycle after enable.
    always @(posedge clk) begin
        if (b0_en) begin
            if (b0_we) begin
                if (b0_wmask[0]) m0[b0_addr][7:0]  <= b0_wdata[7:0];
                if (b0_wmask[1]) m0[b0_addr][15:8] <= b0_wdata[15:8];
            end else begin
                b0_rd <= m0[b0_addr];
            end
        end
        if (b1_en) begin
            if (b1_we) begin
                if (b1_wmask[0]) m1[b1_addr][7:0]  <= b1_wdata[7:0];
                if (b1_wmask[1]) m1[b1_addr][15:8] <= b1_wdata[15:8];
            end else begin
                b1_rd <= m1[b1_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All helper tasks start and end just after a falling edge.
    task automatic lwrite(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        l_req = 1'b1; l_we = 1'b1; l_addr = a; l_wdata = d; l_wstrb = s;
        #1 chk("wr_l_gnt", 32'(l_gnt), 32'd1);
        @(posedge clk); #1;
        chk("wr_no_l_rvalid", 32'(l_rvalid), 32'd0);
        @(negedge clk);
        l_req = 1'b0; l_we = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        f_req = 1'b1; f_addr = a;
        #1 chk({tag, "_gnt"}, 32'(f_gnt), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_rvalid"}, 32'(f_rvalid), 32'd1);
        chk({tag, "_rdata"}, f_rdata, exp);
        @(negedge clk);
        f_req = 1'b0;
    endtask

    task automatic lread(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        l_req = 1'b1; l_we = 1'b0; l_addr = a;
        #1 chk({tag, "_gnt"}, 32'(l_gnt), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_rvalid"}, 32'(l_rvalid), 32'd1);
        chk({tag, "_rdata"}, l_rdata, exp);
        @(negedge clk);
        l_req = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b1; f_req = 1'b1; f_addr = '0; l_req = 1'b1; l_we = 1'b0;
        l_addr = '0; l_wdata = '0; l_wstrb = '0; boot_done = 1'b0;

        @(negedge clk); #1;
        chk("rst_f_gnt", 32'(f_gnt), 32'd0);
        chk("rst_l_gnt", 32'(l_gnt), 32'd0);
        chk("rst_b_en", 32'({b0_en, b1_en, b0_we, b1_we}), 32'd0);
        chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rst_f_rdata", f_rdata, 32'd0);
        chk("rst_l_rdata", l_rdata, 32'd0);
        @(negedge clk);
        l_req = 1'b0;
        reset = 1'b0;
`ifdef ITCM_BOOT_HOLD_EN
        for (int i = 0; i < 3; i++) begin
            #1 chk("boot_f_gnt_held", 32'(f_gnt), 32'd0);
            @(negedge clk);
        end
        boot_done = 1'b1;
        #1 chk("boot_done_cycle_f_gnt", 32'(f_gnt), 32'd0);
        @(negedge clk);
        boot_done = 1'b0;
        #1 chk("run_f_gnt", 32'(f_gnt), 32'd1);
        @(negedge clk);
`else
        #1 chk("first_cycle_f_gnt", 32'(f_gnt), 32'd1);
        @(negedge clk);
`endif
        f_req = 1'b0;
        @(negedge clk);

        // Full word write then aligned fetch
        lwrite(10'd5, 32'hDEADBEEF, 4'hF);
        chk("b1_word5", 32'(m1[5]), 32'h0000BEEF);
        chk("b0_word5", 32'(m0[5]), 32'h0000DEAD);
        fetch("fetch_0x14", 12'h014, 32'hDEADBEEF);

        // Partial write onto bank0 low byte only
        l_req = 1'b1; l_we = 1'b1; l_addr = 10'd5; l_wdata = 32'hAABBCCDD; l_wstrb = 4'h4;
        #1;
        chk("part_b1_en", 32'(b1_en), 32'd0);
        chk("part_b0_en", 32'(b0_en), 32'd1);
        chk("part_b0_wmask", 32'(b0_wmask), 32'd1);
        chk("part_b0_wdata", 32'(b0_wdata), 32'h0000AABB);
        @(negedge clk);
        l_req = 1'b0; l_we = 1'b0;
        lread("part_read", 10'd5, 32'hDEBBBEEF);

        // Misaligned fetch across words 5 and 6
        lwrite(10'd5, 32'h11112222, 4'hF);
        lwrite(10'd6, 32'h33334444, 4'hF);
        f_addr = 12'h016;
        f_req = 1'b1;
        #1 chk("mis_b1_addr", 32'(b1_addr), 32'd6);
        chk("mis_b0_addr", 32'(b0_addr), 32'd5);
        f_req = 1'b0;
        fetch("fetch_0x16", 12'h016, 32'h44441111);

        // Misaligned fetch at the top of memory wraps bank1 to index 0
        lwrite(10'd1023, 32'h55556666, 4'hF);
        lwrite(10'd0, 32'h77778888, 4'hF);
        f_addr = 12'hFFE;
        f_req = 1'b1;
        #1 chk("wrap_b1_addr", 32'(b1_addr), 32'd0);
        f_req = 1'b0;
        fetch("fetch_wrap", 12'hFFE, 32'h88885555);

        // Both requesters held: four fetches then one loader slot, repeating
        f_req = 1'b1; f_addr = 12'h014; l_req = 1'b1; l_we = 1'b0; l_addr = 10'd5;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("arb_f_gnt", 32'(f_gnt), 32'((i % 5) != 4));
            chk("arb_l_gnt", 32'(l_gnt), 32'((i % 5) == 4));
            @(posedge clk); #1;
            chk("arb_f_rvalid", 32'(f_rvalid), 32'((i % 5) != 4));
            chk("arb_l_rvalid", 32'(l_rvalid), 32'((i % 5) == 4));
            if ((i % 5) == 4) chk("arb_l_rdata", l_rdata, 32'h11112222);
            else              chk("arb_f_rdata", f_rdata, 32'h11112222);
            @(negedge clk);
        end
        f_req = 1'b0; l_req = 1'b0;
        @(negedge clk);

        // Reset asserted right after a fetch grant drops the response
        f_req = 1'b1; f_addr = 12'h014;
        #1 chk("mid_f_gnt", 32'(f_gnt), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("mid_rst_f_rdata", f_rdata, 32'd0);
        chk("mid_rst_f_gnt", 32'(f_gnt), 32'd0);
        chk("mid_rst_b_en", 32'({b0_en, b1_en}), 32'd0);
        @(negedge clk);
        f_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("post_rst_l_rvalid", 32'(l_rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
